// File: rtl/fir_mac_if.sv
// fir_mac_if
// Handshake and configuration bundle for the time-multiplexed FIR sequencer.
//   in_valid/in_ready/in_data     : sample input, valid/ready
//   out_valid/out_ready/out_data  : filtered output, valid/ready
//   coef_we/coef_addr/coef_wdata  : coefficient bank write port
//   busy                          : sequencer is not idle
// master: the source/consumer/config side.  slave: the filter itself.
interface fir_mac_if #(
  parameter int AW = 3
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic signed [15:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [15:0]   out_data;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [15:0]   coef_wdata;
  logic                 busy;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR filter: a single signed 16x16 multiplier is stepped
// over TAPS coefficients per input sample. Holds the sample delay line as a
// circular buffer and a runtime-writable Q15 coefficient bank. Output is
// rounded to Q15 scaling: y = (acc + 2**14) >>> 15.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : fir_mac_if.slave (sample in, result out, coef writes, busy)
//
// Configuration macro FIR_SAT_EN:
//   defined   -> y is clamped to [-32768, 32767] before loading out_data
//   undefined -> out_data is the low 16 bits of y (two's-complement wrap)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a sample; coefficient writes accepted
// MAC    | k < TAPS: accumulate one product; k == TAPS: round and load
// HOLD   | out_valid held with stable out_data until out_ready
module fir_mac_sequencer #(
  parameter int TAPS = 5,
  parameter int AW   = 3,
  parameter int ACCW = 40
) (
  input  logic     clk,
  input  logic     reset,
  fir_mac_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [AW:0]             TAPS_W = (AW+1)'(TAPS);
  localparam logic signed [ACCW-1:0]  RND    = ACCW'(16384);
  localparam logic signed [ACCW-1:0]  Y_MAX  = ACCW'(32767);
  localparam logic signed [ACCW-1:0]  Y_MIN  = ACCW'(-32768);

  logic [1:0]              state;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           newest;
  // One step past the last tap (k == TAPS) is the rounding/output cycle.
  logic [AW:0]             k;
  logic signed [ACCW-1:0]  acc;
  logic signed [15:0]      out_data_q;
  logic signed [15:0]      dly_mem  [TAPS];
  logic signed [15:0]      coef_mem [TAPS];

  logic [AW:0]             rd_sum;
  logic [AW-1:0]           rd_idx;
  logic signed [31:0]      prod;
  logic signed [ACCW-1:0]  acc_rnd;
  logic signed [ACCW-1:0]  y_full;
  logic signed [15:0]      y_out;
  logic                    coef_hit;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_data  = out_data_q;

  assign coef_hit = (state == S_IDLE) && bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_W);

  always_comb begin
    // (newest - k) mod TAPS without a divider: bias by TAPS, fold once.
    rd_sum  = {1'b0, newest} + TAPS_W - k;
    rd_idx  = AW'((rd_sum >= TAPS_W) ? (rd_sum - TAPS_W) : rd_sum);
    prod    = coef_mem[k[AW-1:0]] * dly_mem[rd_idx];
    acc_rnd = acc + RND;
    y_full  = acc_rnd >>> 15;
`ifdef FIR_SAT_EN
    if (y_full > Y_MAX) begin
      y_out = 16'sh7fff;
    end else if (y_full < Y_MIN) begin
      y_out = 16'sh8000;
    end else begin
      y_out = 16'(y_full);
    end
`else
    y_out = 16'(y_full);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      newest     <= '0;
      k          <= '0;
      acc        <= '0;
      out_data_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dly_mem[i]  <= '0;
        coef_mem[i] <= '0;
      end
    end else begin
      if (coef_hit) begin
        coef_mem[bus.coef_addr] <= bus.coef_wdata;
      end

      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            dly_mem[wr_ptr] <= bus.in_data;
            newest          <= wr_ptr;
            if ({1'b0, wr_ptr} == TAPS_W - 1'b1) begin
              wr_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            acc   <= '0;
            k     <= '0;
            state <= S_MAC;
          end
        end

        S_MAC: begin
          if (k == TAPS_W) begin
            out_data_q <= y_out;
            state      <= S_HOLD;
          end else begin
            acc <= acc + ACCW'(prod);
            k   <= k + 1'b1;
          end
        end

        S_HOLD: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: directed impulse/handshake/gating/
// saturation/wrap/reset scenarios plus randomized samples and coefficient
// writes, all checked against a plain-arithmetic convolution model.
module tb_fir_mac_sequencer;
  localparam int TAPS = 5;
  localparam int AW   = 3;
  localparam int ACCW = 40;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  fir_mac_if #(.AW(AW)) bus ();

  fir_mac_sequencer #(.TAPS(TAPS), .AW(AW), .ACCW(ACCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int mcoef [TAPS];
  int hist  [$];
  int imp_coef [TAPS] = '{1153, 7925, 14758, 7925, 1153};
  int imp_exp  [6]    = '{577, 3963, 7379, 3963, 577, 0};
  int unity    [TAPS] = '{6554, 6553, 6554, 6553, 6554};

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // y[n] = round(sum h[k]*x[n-k] / 2**15), missing history reads as zero.
  function automatic longint model_y();
    longint acc = 0;
    longint y;
    for (int j = 0; j < TAPS; j++) begin
      int idx;
      longint x;
      idx = hist.size() - 1 - j;
      x   = (idx >= 0) ? longint'(hist[idx]) : 0;
      acc += longint'(mcoef[j]) * x;
    end
    y = (acc + 16384) >>> 15;
`ifdef FIR_SAT_EN
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
`else
    y = y & 64'hFFFF;
    if (y >= 32768) y = y - 65536;
`endif
    return y;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int j = 0; j < TAPS; j++) mcoef[j] = 0;
  endtask

  task automatic write_coef(input int addr, input int val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = addr[AW-1:0];
    bus.coef_wdata = val[15:0];
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (addr < TAPS) mcoef[addr] = val;
  endtask

  task automatic load_coefs(input int c [TAPS]);
    for (int j = 0; j < TAPS; j++) write_coef(j, c[j]);
  endtask

  // Offers one sample, checks latency, holds the output for 'hold' cycles,
  // then completes the handshake. busy_wr pulses coef[2]=0 mid-MAC.
  task automatic send_sample(input int x, input int hold, input bit busy_wr, output longint y);
    int lat;
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x[15:0];
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    hist.push_back(x);
    check("busy_in_mac", bus.busy, 1);
    check("in_ready_in_mac", bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy_wr && lat == 2) begin
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'd2;
        bus.coef_wdata = 16'sd0;
      end
      if (lat == 3) bus.coef_we = 1'b0;
    end
    check("latency", lat, TAPS + 1);
    y = model_y();
    check("out_data", longint'($signed(bus.out_data)), y);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", longint'($signed(bus.out_data)), y);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  task automatic run_impulse(input bit busy_wr, input string tag);
    longint y;
    for (int i = 0; i < 6; i++) begin
      send_sample((i == 0) ? 16384 : 0, 0, busy_wr && (i == 0), y);
      check(tag, y, imp_exp[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint y;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_data", longint'($signed(bus.out_data)), 0);

    // Impulse response
    load_coefs(imp_coef);
    run_impulse(1'b0, "impulse");

    // Output held while downstream stalls
    send_sample(1234, 10, 1'b0, y);
    for (int i = 0; i < TAPS - 1; i++) send_sample(0, 0, 1'b0, y);

    // Coefficient write while busy is ignored; in IDLE it takes effect
    run_impulse(1'b1, "gated_impulse");
    write_coef(2, 0);
    for (int i = 0; i < 6; i++) begin
      send_sample((i == 0) ? 16384 : 0, 0, 1'b0, y);
      if (i == 2) check("mid_tap_zero", y, 0);
    end

    // Out-of-range address is ignored
    write_coef(6, 12345);
    write_coef(7, -999);

    // Saturation / wrap of the full-scale sum
    for (int j = 0; j < TAPS; j++) write_coef(j, 32767);
    for (int i = 0; i < TAPS; i++) send_sample(32767, 0, 1'b0, y);
`ifdef FIR_SAT_EN
    check("sat_fifth", y, 32767);
`else
    check("wrap_fifth", y, 32758);
`endif

    // Delay-line pointer wrap with unity-gain coefficients
    load_coefs(unity);
    for (int i = 0; i < 12; i++) send_sample(1000, 0, 1'b0, y);
    check("unity_steady", y, 1000);

    // Randomized samples, holds and coefficient writes
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_coef(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)) - 32768);
      send_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)), 1'b0, y);
    end

    // Reset during MAC discards the sample and clears history and coefs
    load_coefs(imp_coef);
    send_sample(5000, 0, 1'b0, y);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd16384;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    load_coefs(imp_coef);
    run_impulse(1'b0, "post_reset_impulse");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
